// File: rtl/char_detector.sv
// Character-match detector: flags 'a'/'b'/'c' (optionally upper case) with a
// stretchable registered request pulse, the id of the newest match and a saturating hit count.
module char_detector #(
    parameter int unsigned HOLD_CYCLES      = 1,  // legal range 1..255
    parameter bit          CASE_INSENSITIVE = 1'b0
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [7:0] char,
    output logic       is_true1,
    output logic [1:0] match_id,
    output logic [7:0] hit_count
);

    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

    logic [7:0] foldedChar;
    logic       charMatch;
    logic [1:0] charId;

    logic       isTrue_q,   isTrue_d;
    logic [1:0] matchId_q,  matchId_d;
    logic [7:0] hitCount_q, hitCount_d;
    logic [7:0] holdCnt_q,  holdCnt_d;

    // Upper case is folded onto lower case so both share one decode and one id;
    // the low two bits of 0x61..0x63 are already the ids 01..11.
    always_comb begin
        foldedChar = char;
        if (CASE_INSENSITIVE && (char >= 8'h41) && (char <= 8'h43)) begin
            foldedChar = char | 8'h20;
        end
        charMatch = (foldedChar >= 8'h61) && (foldedChar <= 8'h63);
        charId    = charMatch ? foldedChar[1:0] : 2'b00;
    end

    always_comb begin
        isTrue_d   = isTrue_q;
        matchId_d  = matchId_q;
        hitCount_d = hitCount_q;
        holdCnt_d  = holdCnt_q;
        if (charMatch) begin
            isTrue_d  = 1'b1;
            matchId_d = charId;
            holdCnt_d = HOLD_RELOAD;
            if (hitCount_q != 8'hFF) begin
                hitCount_d = hitCount_q + 8'd1;
            end
        end else if (holdCnt_q != 8'd0) begin
            holdCnt_d = holdCnt_q - 8'd1;
        end else begin
            isTrue_d  = 1'b0;
            matchId_d = 2'b00;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            isTrue_q   <= 1'b0;
            matchId_q  <= 2'b00;
            hitCount_q <= 8'd0;
            holdCnt_q  <= 8'd0;
        end else begin
            isTrue_q   <= isTrue_d;
            matchId_q  <= matchId_d;
            hitCount_q <= hitCount_d;
            holdCnt_q  <= holdCnt_d;
        end
    end

    assign is_true1  = isTrue_q;
    assign match_id  = matchId_q;
    assign hit_count = hitCount_q;

endmodule

// File: tb/tb_char_detector.sv
// Bench for char_detector: three instances with different HOLD_CYCLES/CASE_INSENSITIVE
// share one stimulus stream and are compared every cycle against an event-history model.
module tb_char_detector;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] char  = 8'h00;

    logic [2:0]      isTrue;
    logic [2:0][1:0] matchId;
    logic [2:0][7:0] hitCount;

    int tests = 0;
    int fails = 0;

    int holdOf [3] = '{1, 4, 3};
    bit ciOf   [3] = '{1'b0, 1'b0, 1'b1};

    byte unsigned lowerSet [3] = '{8'h61, 8'h62, 8'h63};
    byte unsigned upperSet [3] = '{8'h41, 8'h42, 8'h43};

    int edgeNo = 0;
    int lastMatch [3] = '{-1, -1, -1};
    int lastId    [3] = '{0, 0, 0};
    int hits      [3] = '{0, 0, 0};

    char_detector #(.HOLD_CYCLES(1), .CASE_INSENSITIVE(1'b0)) dutA (
        .clock(clock), .clear(clear), .char(char),
        .is_true1(isTrue[0]), .match_id(matchId[0]), .hit_count(hitCount[0])
    );
    char_detector #(.HOLD_CYCLES(4), .CASE_INSENSITIVE(1'b0)) dutB (
        .clock(clock), .clear(clear), .char(char),
        .is_true1(isTrue[1]), .match_id(matchId[1]), .hit_count(hitCount[1])
    );
    char_detector #(.HOLD_CYCLES(3), .CASE_INSENSITIVE(1'b1)) dutC (
        .clock(clock), .clear(clear), .char(char),
        .is_true1(isTrue[2]), .match_id(matchId[2]), .hit_count(hitCount[2])
    );

    always #5 clock = ~clock;

    function automatic int modelId(input byte unsigned c, input bit ci);
        for (int i = 0; i < 3; i++) begin
            if (c == lowerSet[i] || (ci && c == upperSet[i])) return i + 1;
        end
        return 0;
    endfunction

    // The flag is high while fewer than HOLD edges have passed since the newest match.
    function automatic int expTrue(input int k);
        return (lastMatch[k] >= 0 && (edgeNo - lastMatch[k]) < holdOf[k]) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] c);
        @(posedge clock);
        #2 char = c;
    endtask

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            edgeNo = 0;
            for (int k = 0; k < 3; k++) begin
                lastMatch[k] = -1;
                lastId[k]    = 0;
                hits[k]      = 0;
            end
        end else begin
            edgeNo++;
            for (int k = 0; k < 3; k++) begin
                int id;
                id = modelId(char, ciOf[k]);
                if (id != 0) begin
                    lastMatch[k] = edgeNo;
                    lastId[k]    = id;
                    hits[k]      = (hits[k] < 255) ? hits[k] + 1 : 255;
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("cyc is_true1[%0d]", k), int'(isTrue[k]), expTrue(k));
            checkOutput($sformatf("cyc match_id[%0d]", k), int'(matchId[k]),
                        expTrue(k) != 0 ? lastId[k] : 0);
            checkOutput($sformatf("cyc hit_count[%0d]", k), int'(hitCount[k]), hits[k]);
        end
    end

    initial begin
        logic [7:0] seq [9];
        logic [7:0] c;
        int r;

        clear = 1'b0;
        char  = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset is_true1", int'(isTrue[0]), 0);
        checkOutput("reset match_id", int'(matchId[0]), 0);
        checkOutput("reset hit_count", int'(hitCount[1]), 0);
        #1 clear = 1'b1;

        // One 'b' with HOLD 1: exactly one cycle of flag
        applyStimulus(8'h62);
        applyStimulus(8'h7A);
        checkOutput("basic is_true1", int'(isTrue[0]), 1);
        checkOutput("basic match_id", int'(matchId[0]), 2);
        checkOutput("basic hit_count", int'(hitCount[0]), 1);
        applyStimulus(8'h7A);
        checkOutput("basic drop is_true1", int'(isTrue[0]), 0);
        checkOutput("basic drop match_id", int'(matchId[0]), 0);
        checkOutput("basic hold4 still high", int'(isTrue[1]), 1);

        applyStimulus(8'h63);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'h20);
            checkOutput($sformatf("stretch is_true1 %0d", i), int'(isTrue[1]), (i < 4) ? 1 : 0);
            checkOutput($sformatf("stretch match_id %0d", i), int'(matchId[1]), (i < 4) ? 3 : 0);
        end

        seq = '{8'h61, 8'h20, 8'h20, 8'h63, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
        applyStimulus(seq[0]);
        for (int j = 0; j < 9; j++) begin
            applyStimulus((j < 8) ? seq[j + 1] : 8'h20);
            checkOutput($sformatf("retrig is_true1 %0d", j), int'(isTrue[1]), (j <= 6) ? 1 : 0);
            checkOutput($sformatf("retrig match_id %0d", j), int'(matchId[1]),
                        (j < 3) ? 1 : ((j <= 6) ? 3 : 0));
        end

        // Async clear mid-cycle after five hits
        clear = 1'b0;
        @(posedge clock);
        #2 clear = 1'b1;
        repeat (6) applyStimulus(8'h61);
        checkOutput("pre-clear hit_count", int'(hitCount[1]), 5);
        checkOutput("pre-clear is_true1", int'(isTrue[1]), 1);
        #1 clear = 1'b0;
        #1;
        checkOutput("async clear is_true1", int'(isTrue[1]), 0);
        checkOutput("async clear match_id", int'(matchId[1]), 0);
        checkOutput("async clear hit_count", int'(hitCount[1]), 0);
        repeat (3) applyStimulus(8'h61);
        checkOutput("held clear is_true1", int'(isTrue[1]), 0);
        checkOutput("held clear hit_count", int'(hitCount[1]), 0);
        char  = 8'h20;
        clear = 1'b1;

        for (int v = 0; v < 256; v++) begin
            if (v < 8'h61 || v > 8'h63) applyStimulus(8'(v));
        end
        applyStimulus(8'h20);
        checkOutput("sweep hit_count h1", int'(hitCount[0]), 0);
        checkOutput("sweep hit_count h4", int'(hitCount[1]), 0);
        checkOutput("sweep is_true1 h1", int'(isTrue[0]), 0);
        checkOutput("sweep hit_count ci", int'(hitCount[2]), 3);

        applyStimulus(8'h41);
        applyStimulus(8'h20);
        checkOutput("upper A ci match_id", int'(matchId[2]), 1);
        checkOutput("upper A ci is_true1", int'(isTrue[2]), 1);
        checkOutput("upper A cs is_true1", int'(isTrue[0]), 0);

        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                c = (r < 3) ? lowerSet[r] : upperSet[$urandom_range(0, 2)];
            end else begin
                c = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 199) == 0) begin
                clear = 1'b0;
                applyStimulus(c);
                clear = 1'b1;
            end else begin
                applyStimulus(c);
            end
        end

        repeat (300) applyStimulus(8'h61);
        applyStimulus(8'h61);
        checkOutput("saturate hit_count", int'(hitCount[0]), 255);
        checkOutput("saturate is_true1", int'(isTrue[0]), 1);

        applyStimulus(8'h20);
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
